instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Fetch stage upstream of operand fetch: owns the PC, issues word reads to instruction memory
//   over a req/ack handshake, and buffers returned words with their PCs in a small FIFO.
//   Presents {instruction, PC} to operand fetch with a valid/ready handshake.
//   A taken branch from the branch unit redirects the PC, flushes the FIFO and squashes in-flight data.
// PARAMETERS
//   ADDR_W      32    PC / instruction-memory address width
//   RESET_PC    0     PC of the first instruction fetched after reset
//   FIFO_DEPTH  2     instruction buffer entries (power of two, >=2)
// PORTS
//   clk              in   1       clock, all state updates on rising edge
//   rst              in   1       asynchronous, active-high reset
//   branch_taken_in  in   1       redirect strobe from branch unit (1-cycle pulse)
//   branch_pc_in     in   ADDR_W  redirect target, sampled when branch_taken_in=1
//   imem_req_out     out  1       read request to instruction memory
//   imem_addr_out    out  ADDR_W  read address; stable while imem_req_out=1 until ack
//   imem_ack_in      in   1       memory accepts and returns the word this cycle
//   imem_data_in     in   32      instruction word, valid when imem_ack_in=1
//   instr_out        out  32      instruction at FIFO head -> operand fetch
//   pc_out           out  ADDR_W  PC of instr_out
//   instr_valid_out  out  1       FIFO non-empty
//   instr_ready_in   in   1       operand fetch consumes head when valid&ready
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req_out=0,
//     imem_addr_out=RESET_PC, instr_valid_out=0, instr_out=0, pc_out=0.
//   instr_out/pc_out: FIFO head when valid, 0 when empty. pop = instr_valid_out & instr_ready_in.
//   Transfer = imem_req_out & imem_ack_in (same-cycle ack allowed). At most one request outstanding.
//   imem_req_out=1 in REQ and DROP; imem_addr_out = fetch_pc (REQ) / held squashed addr (DROP).
//   FSM:
//     IDLE: no request. -> REQ when count<FIFO_DEPTH (registered count). First edge after reset -> REQ.
//     REQ : on transfer: push {imem_data_in, fetch_pc}; fetch_pc += 4 (mod 2^ADDR_W, wraps to 0);
//           next = REQ if (count+1-pop)<FIFO_DEPTH else IDLE. No transfer: hold addr, stay REQ.
//     DROP: old address held with req=1 until ack; acked data discarded (no push); -> REQ at ack.
//   Redirect (branch_taken_in=1), highest priority:
//     - FIFO flushed at that edge; pop in same cycle ignored; instr_valid_out=0 next cycle.
//     - fetch_pc <= branch_pc_in.
//     - in IDLE, or in REQ with transfer same cycle: acked word discarded, -> REQ (addr=branch_pc_in).
//     - in REQ without transfer: -> DROP (handshake protocol forbids changing addr mid-request).
//     - in DROP: update fetch_pc to newest target, stay DROP (or -> REQ if ack this cycle).
//   Push and pop in same cycle: count unchanged; full FIFO never pushed (request gated by count).
//   Latency: ack in cycle n -> instr_valid_out in cycle n+1. Zero-wait memory + ready=1: 1 instr/cycle.
//   Low two bits of fetch_pc are never generated nonzero by +4; branch_pc_in taken as given.
// TESTING
//   1 Reset release, ack=1 always, ready=1 -> req in 1st cycle, addr 0x0; pc_out 0x0,0x4,0x8 on consecutive cycles.
//   2 ready=0, ack=1 -> 2 entries buffered (pc 0x0,0x4), req drops to 0; ready=1 -> drains in order, req resumes at 0x8.
//   3 ack delayed 3 cycles -> imem_addr_out and req stable through wait; data 0xDEADBEEF appears with pc_out of that addr.
//   4 redirect to 0x100 while request to 0x8 unacked -> DROP, addr stays 0x8 until ack, word discarded, next req addr 0x100.
//   5 redirect to 0x200 same cycle as ack and pop -> no old-stream instr ever valid; next valid pc_out=0x200.
//   6 fetch_pc=0xFFFFFFFC fetched -> next req addr 0x0; assert rst mid-request -> all outputs reset value without clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, fetches over an imem req/ack handshake and
// buffers {instr, pc} in a small FIFO toward operand fetch.
module instruction_fetch #(
  parameter int unsigned    ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned    FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken_in,
  input  logic [ADDR_W-1:0] branch_pc_in,
  output logic              imem_req_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic              imem_ack_in,
  input  logic [31:0]       imem_data_in,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid_out,
  input  logic              instr_ready_in
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_drop_addr;
  logic [31:0]       r_instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_pc_mem    [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_xfer;
  logic              w_push;
  logic              w_pop;

  assign instr_valid_out = (r_count != '0);
  assign imem_req_out    = (r_state == REQ) || (r_state == DROP);
  assign imem_addr_out   = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
  assign instr_out       = instr_valid_out ? r_instr_mem[r_rptr] : '0;
  assign pc_out          = instr_valid_out ? r_pc_mem[r_rptr] : '0;

  assign w_xfer = imem_req_out & imem_ack_in;
  // A redirect overrides both sides of the FIFO in the same cycle.
  assign w_push = (r_state == REQ) & imem_ack_in & ~branch_taken_in;
  assign w_pop  = instr_valid_out & instr_ready_in & ~branch_taken_in;
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (branch_taken_in) w_state_nxt = REQ;
        else if (r_count < DEPTH_C) w_state_nxt = REQ;
      end
      REQ: begin
        if (branch_taken_in) w_state_nxt = w_xfer ? REQ : DROP;
        else if (w_xfer) w_state_nxt = (w_cnt_nxt < DEPTH_C) ? REQ : IDLE;
      end
      DROP: begin
        if (imem_ack_in) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (branch_taken_in) r_fetch_pc <= branch_pc_in;
      else if (w_push) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      // The in-flight address must stay on the bus until memory acks it.
      if (r_state == REQ && branch_taken_in && !w_xfer)
        r_drop_addr <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (branch_taken_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wptr] <= imem_data_in;
      r_pc_mem[r_wptr]    <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// Default memory returns 0xC0DE0000 ^ addr; fixed words override it.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken_in;
  logic [31:0] branch_pc_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_data_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        instr_ready_in;

  logic        fix_en;
  logic [31:0] fix_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    imem_data_in = 32'hC0DE0000 ^ imem_addr_out;
    if (fix_en) imem_data_in = fix_val;
  end

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .branch_taken_in (branch_taken_in),
    .branch_pc_in    (branch_pc_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_ack_in     (imem_ack_in),
    .imem_data_in    (imem_data_in),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    branch_taken_in = 1'b0;
    branch_pc_in = '0;
    imem_ack_in = 1'b0;
    instr_ready_in = 1'b0;
    fix_en = 1'b0;
    fix_val = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // reset values
    reset_dut();
    chk("rst_req", 32'(imem_req_out), 32'd0);
    chk("rst_addr", imem_addr_out, 32'h0);
    chk("rst_valid", 32'(instr_valid_out), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);

    // T1: streaming
    imem_ack_in = 1'b1;
    instr_ready_in = 1'b1;
    step();
    chk("t1_req", 32'(imem_req_out), 32'd1);
    chk("t1_addr0", imem_addr_out, 32'h0);
    step();
    chk("t1_pc0", pc_out, 32'h0);
    chk("t1_ins0", instr_out, 32'hC0DE0000);
    step();
    chk("t1_pc4", pc_out, 32'h4);
    chk("t1_ins4", instr_out, 32'hC0DE0004);
    step();
    chk("t1_pc8", pc_out, 32'h8);
    chk("t1_v8", 32'(instr_valid_out), 32'd1);

    // T2: backpressure fills the FIFO
    reset_dut();
    imem_ack_in = 1'b1;
    step();
    chk("t2_addr0", imem_addr_out, 32'h0);
    step();
    chk("t2_addr4", imem_addr_out, 32'h4);
    step();
    chk("t2_req_off", 32'(imem_req_out), 32'd0);
    chk("t2_head0", pc_out, 32'h0);
    step();
    chk("t2_req_off2", 32'(imem_req_out), 32'd0);
    instr_ready_in = 1'b1;
    step();
    chk("t2_head4", pc_out, 32'h4);
    chk("t2_req_off3", 32'(imem_req_out), 32'd0);
    step();
    chk("t2_req_on", 32'(imem_req_out), 32'd1);
    chk("t2_addr8", imem_addr_out, 32'h8);
    chk("t2_empty", 32'(instr_valid_out), 32'd0);
    step();
    chk("t2_pc8", pc_out, 32'h8);

    // T3: wait states
    reset_dut();
    instr_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_wreq", 32'(imem_req_out), 32'd1);
      chk("t3_waddr", imem_addr_out, 32'h0);
    end
    step();
    chk("t3_addr_ack", imem_addr_out, 32'h0);
    fix_en = 1'b1;
    fix_val = 32'hDEADBEEF;
    imem_ack_in = 1'b1;
    step();
    imem_ack_in = 1'b0;
    fix_en = 1'b0;
    chk("t3_ins", instr_out, 32'hDEADBEEF);
    chk("t3_pc", pc_out, 32'h0);
    chk("t3_next", imem_addr_out, 32'h4);

    // T4: redirect during an unacked request
    reset_dut();
    imem_ack_in = 1'b1;
    instr_ready_in = 1'b1;
    step();
    step();
    step();
    chk("t4_addr8", imem_addr_out, 32'h8);
    imem_ack_in = 1'b0;
    step();
    chk("t4_empty", 32'(instr_valid_out), 32'd0);
    branch_taken_in = 1'b1;
    branch_pc_in = 32'h100;
    step();
    branch_taken_in = 1'b0;
    chk("t4_drop_req", 32'(imem_req_out), 32'd1);
    chk("t4_drop_a", imem_addr_out, 32'h8);
    step();
    chk("t4_drop_b", imem_addr_out, 32'h8);
    fix_en = 1'b1;
    fix_val = 32'h0BAD0BAD;
    imem_ack_in = 1'b1;
    step();
    fix_en = 1'b0;
    chk("t4_discard", 32'(instr_valid_out), 32'd0);
    chk("t4_new_addr", imem_addr_out, 32'h100);
    step();
    chk("t4_pc100", pc_out, 32'h100);
    chk("t4_ins100", instr_out, 32'hC0DE0100);

    // T5: redirect with ack and pop in the same cycle
    reset_dut();
    imem_ack_in = 1'b1;
    instr_ready_in = 1'b1;
    step();
    step();
    chk("t5_pc0", pc_out, 32'h0);
    branch_taken_in = 1'b1;
    branch_pc_in = 32'h200;
    step();
    branch_taken_in = 1'b0;
    chk("t5_flush", 32'(instr_valid_out), 32'd0);
    chk("t5_addr", imem_addr_out, 32'h200);
    step();
    chk("t5_pc200", pc_out, 32'h200);

    // T6: PC wrap, then async reset mid-request
    reset_dut();
    step();
    branch_taken_in = 1'b1;
    branch_pc_in = 32'hFFFFFFFC;
    step();
    branch_taken_in = 1'b0;
    chk("t6_drop", imem_addr_out, 32'h0);
    imem_ack_in = 1'b1;
    step();
    chk("t6_top", imem_addr_out, 32'hFFFFFFFC);
    step();
    imem_ack_in = 1'b0;
    chk("t6_wrap", imem_addr_out, 32'h0);
    chk("t6_pcff", pc_out, 32'hFFFFFFFC);
    step();
    chk("t6_pend", 32'(imem_req_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_areq", 32'(imem_req_out), 32'd0);
    chk("t6_aaddr", imem_addr_out, 32'h0);
    chk("t6_avalid", 32'(instr_valid_out), 32'd0);
    chk("t6_ainstr", instr_out, 32'h0);
    chk("t6_apc", pc_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
